// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register-file write path.
package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 31;
  localparam int unsigned CNT_W    = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Staged write payload between capture and commit
  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_port_decoder5_32.sv
// 5-to-32 one-hot decoder with enable; all-zero output when disabled.
module decoder5_32
  import regfile_pkg::*;
(
  input  logic             en,
  input  reg_addr_t        addr,
  output logic [NREGS-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) onehot_c[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32x64 register file: one staging register, commit one
// cycle later, X31 reads as zero and is never stored.
module regfile_write_port
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  reg_addr_t               wr_addr,
  input  reg_data_t               wr_data,
  input  logic                    flush,
  output logic [NREGS*DATA_W-1:0] regs_out,
  output logic                    pend_valid,
  output reg_addr_t               pend_addr,
  output reg_data_t               pend_data,
  output logic [NREGS-1:0]        wr_onehot,
  output logic [CNT_W-1:0]        commit_cnt
);

  localparam int unsigned NSTORE = NREGS - 1;

  wr_req_t          pend_q, pend_d;
  logic [NREGS-1:0] wr_onehot_q, wr_onehot_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
  reg_data_t        regs_q [NSTORE];
  reg_data_t        regs_d [NSTORE];

  logic             capture_c;
  logic             commit_c;
  logic [NREGS-1:0] dec_onehot_c;

  assign capture_c = wr_en && (wr_addr != ADDR_W'(ZERO_REG));
  assign commit_c  = pend_q.valid && !flush;

  decoder5_32 u_dec (
    .en       (capture_c),
    .addr     (wr_addr),
    .onehot_c (dec_onehot_c)
  );

  // Capture stage: address/data hold when nothing is staged
  always_comb begin
    pend_d       = pend_q;
    pend_d.valid = capture_c;
    if (capture_c) begin
      pend_d.addr = wr_addr;
      pend_d.data = wr_data;
    end
    wr_onehot_d = dec_onehot_c;
  end

  // Commit stage: only the register selected by the staged one-hot changes
  always_comb begin
    regs_d       = regs_q;
    commit_cnt_d = commit_cnt_q;
    for (int i = 0; i < int'(NSTORE); i++) begin
      if (commit_c && wr_onehot_q[i]) regs_d[i] = pend_q.data;
    end
    if (commit_c && (commit_cnt_q != '1)) commit_cnt_d = commit_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q       <= '0;
      wr_onehot_q  <= '0;
      commit_cnt_q <= '0;
      for (int i = 0; i < int'(NSTORE); i++) regs_q[i] <= '0;
    end else begin
      pend_q       <= pend_d;
      wr_onehot_q  <= wr_onehot_d;
      commit_cnt_q <= commit_cnt_d;
      regs_q       <= regs_d;
    end
  end

  for (genvar g = 0; g < int'(NSTORE); g++) begin : g_regs_out
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end
  assign regs_out[ZERO_REG*DATA_W +: DATA_W] = '0;

  assign pend_valid = pend_q.valid;
  assign pend_addr  = pend_q.addr;
  assign pend_data  = pend_q.data;
  assign wr_onehot  = wr_onehot_q;
  assign commit_cnt = commit_cnt_q;

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 32-entry, 64-bit register file. Its counterpart is the 5-bit-select read mux tree, which consumes the flattened array this block exposes.
- Decodes a 5-bit write address to a one-hot enable vector and stages each write through one pending register.
- Commits the staged write into the storage array one cycle later.
- Exposes the pending write so the read path can forward it. X31 is hard-wired zero (XZR).

Parameters:
- DATA_W, 64, register width in bits
- NREGS, 32, number of registers (fixed at 32; the address is 5 bits)
- ZERO_REG, 31, index that always reads zero and ignores writes

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- wr_en  input  1  write request this cycle
- wr_addr  input  5  destination register
- wr_data  input  DATA_W  write data
- flush  input  1  cancel the pending (uncommitted) write
- regs_out  output  NREGS*DATA_W  flattened array; register i occupies bits [i*DATA_W +: DATA_W]
- pend_valid  output  1  a staged write awaits commit
- pend_addr  output  5  staged destination
- pend_data  output  DATA_W  staged data
- wr_onehot  output  NREGS  registered one-hot decode of the staged address (all-zero when pend_valid=0)
- commit_cnt  output  16  number of committed writes, saturating

Behaviour:
- Reset: already decided — one clock; reset is synchronous and active-low. At any edge with reset_n=0, every output is forced to 0: all registers, pend_valid, pend_addr, pend_data, wr_onehot and commit_cnt. A staged write is discarded (reset mid-operation).
- Stage 1 (capture), edge N:
  - If wr_en=1 and wr_addr!=ZERO_REG: pend_valid<=1, pend_addr<=wr_addr, pend_data<=wr_data, wr_onehot<=1<<wr_addr.
  - Otherwise pend_valid<=0 and wr_onehot<=0. pend_addr and pend_data hold their values; they are don't-care while pend_valid=0.
- Stage 2 (commit), edge N+1:
  - If pend_valid=1 and flush=0: reg[pend_addr]<=pend_data and commit_cnt increments, saturating at 0xFFFF.
  - Only the register selected by wr_onehot changes; all other registers hold.
- Latency: a write presented at edge N is visible on regs_out after edge N+1. During the interval between N and N+1 it is visible only on the pend_* outputs.
- Back-to-back writes at full throughput: at every edge, commit of the old pending write and capture of the new one happen together.
- Same-address back-to-back writes: the older value commits at N+1 and the newer at N+2. The final value is the newer one.
- flush:
  - Blocks the commit of the current pending write at that edge.
  - Does not block capture of a new wr_en at the same edge; the new write is staged normally.
- Zero register: reg[ZERO_REG] is constant 0 and is never stored. A write to ZERO_REG is dropped at capture: no pend_valid, no count.
- regs_out is a direct register output with no combinational path from the inputs.

Decomposition:
- Shared package regfile_pkg holds DATA_W, NREGS, ZERO_REG and typedef reg_addr_t (logic [4:0]).
- The same package holds typedef reg_data_t (logic [DATA_W-1:0]).
- One natural sub-module: decoder5_32, a combinational 5-to-32 one-hot decoder with an enable input. It mirrors the read-side mux32 tree and is reused for wr_onehot.

Test Plan:
1. Reset, then wr_en=1, wr_addr=5, wr_data=0xDEAD_BEEF_0000_0001 for one cycle.
   - After the next edge: pend_valid=1, pend_addr=5, wr_onehot=0x0000_0020.
   - One edge later: reg[5]=0xDEAD_BEEF_0000_0001, pend_valid=0, commit_cnt=1.
2. Write 0x1234 to address 31.
   - pend_valid stays 0 and reg[31] remains 0.
   - commit_cnt is unchanged.
3. Back-to-back writes on consecutive cycles: addr 3=0xA, addr 3=0xB, addr 7=0xC.
   - Final state: reg[3]=0xB, reg[7]=0xC, commit_cnt=3.
   - reg[3] reads 0xA for exactly one cycle before changing to 0xB.
4. Write addr 9=0x55, then assert flush on the commit edge while presenting addr 10=0x66.
   - reg[9] keeps its old value and reg[10]=0x66.
   - commit_cnt increments by 1 only.
5. Stage addr 12=0xFF, then pull reset_n=0 on the next edge.
   - reg[12]=0, pend_valid=0 and commit_cnt=0.
   - The first write after reset commits normally.
6. Perform 65540 writes to addr 1.
   - commit_cnt saturates at 0xFFFF and does not wrap.
   - Registers other than reg[1] stay unchanged throughout.
